// File: rtl/sbox_sequencer.sv
// rtl/sbox_sequencer.sv - time-shares one external S-box table across eight lookups per 48-bit word
module sbox_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:48] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:32] out_data,
   output logic [2:0]  sbox_sel,
   output logic [1:6]  sbox_in,
   input  logic [1:4]  sbox_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [2:0]  k_q;
   logic [2:0]  k_d;
   logic [1:48] word_q;
   logic [1:32] result_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic        busy_q;
   logic [2:0]  sel_q;
   logic [1:6]  sin_q;

   // Lookup address for S-box idx: six-bit chunk idx of the word, MSB first.
   function automatic logic [1:6] chunk(input logic [1:48] w, input logic [2:0] idx);
      logic [1:6] c;
      c = '0;
      case (idx)
         3'd0: c = w[1:6];
         3'd1: c = w[7:12];
         3'd2: c = w[13:18];
         3'd3: c = w[19:24];
         3'd4: c = w[25:30];
         3'd5: c = w[31:36];
         3'd6: c = w[37:42];
         3'd7: c = w[43:48];
      endcase
      return c;
   endfunction

   // Result with nibble idx replaced; every other nibble is left untouched.
   function automatic logic [1:32] put_nibble(input logic [1:32] r, input logic [2:0] idx,
                                              input logic [1:4] n);
      logic [1:32] t;
      t = r;
      case (idx)
         3'd0: t[1:4]   = n;
         3'd1: t[5:8]   = n;
         3'd2: t[9:12]  = n;
         3'd3: t[13:16] = n;
         3'd4: t[17:20] = n;
         3'd5: t[21:24] = n;
         3'd6: t[25:28] = n;
         3'd7: t[29:32] = n;
      endcase
      return t;
   endfunction

   assign k_d = k_q + 3'd1;

   // Sequencer FSM: the table address/select are registered one step ahead so the
   // table sees them for the whole RUN cycle in which its answer is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= 3'd0;
         word_q      <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sel_q       <= 3'd0;
         sin_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  word_q     <= in_data;
                  k_q        <= 3'd0;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  sel_q      <= 3'd0;
                  sin_q      <= chunk(in_data, 3'd0);
               end
            end
            S_RUN: begin
               result_q <= put_nibble(result_q, k_q, sbox_out);
               if (k_q == 3'd7) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  sel_q       <= 3'd0;
                  sin_q       <= '0;
               end else begin
                  k_q   <= k_d;
                  sel_q <= k_d;
                  sin_q <= chunk(word_q, k_d);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  k_q         <= 3'd0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               sel_q       <= 3'd0;
               sin_q       <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = result_q;
   assign busy      = busy_q;
   assign sbox_sel  = sel_q;
   assign sbox_in   = sin_q;

endmodule

// File: tb/tb_sbox_sequencer.sv
// tb/tb_sbox_sequencer.sv - scoreboard bench for sbox_sequencer with a DES S1..S8 table model
module tb_sbox_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:48] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:32] out_data;
   logic [2:0]  sbox_sel;
   logic [1:6]  sbox_in;
   logic [1:4]  sbox_out;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   int tab [0:7][0:63] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
   };

   assign sbox_out = 4'(tab[sbox_sel][{sbox_in[1], sbox_in[6], sbox_in[2:5]}]);

   sbox_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sbox_sel  (sbox_sel),
      .sbox_in   (sbox_in),
      .sbox_out  (sbox_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [47:0] w);
      logic [31:0] r;
      logic [5:0]  a;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         a = 6'(w >> (42 - 6 * k));
         r = {r[27:0], 4'(tab[k][{a[5], a[0], a[4:1]}])};
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual=%h required=none at %0t", out_data, $time);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   // One word with out_ready held high: checks table walk, latency and return to IDLE.
   task automatic run_word(input logic [47:0] w, input logic [31:0] exp, input int s1_exp);
      logic [5:0] a;
      exp_q.push_back(exp);
      in_data  = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = w[47 - 6 * i -: 6];
         check("run_sel", sbox_sel, i);
         check("run_sbox_in", sbox_in, a);
         check("run_flags", {busy, in_ready, out_valid}, 3'b100);
         if (i == 0 && s1_exp >= 0) check("s1_out", sbox_out, s1_exp);
         in_data = ~w;
         tick();
      end
      check("done_flags", {busy, in_ready, out_valid}, 3'b101);
      check("done_sel_in", {sbox_sel, sbox_in}, 9'd0);
      check("done_data", out_data, exp);
      tick();
      check("idle_flags", {busy, in_ready, out_valid}, 3'b010);
      check("idle_retain", out_data, exp);
   endtask

   logic [47:0] w;
   logic [31:0] e;
   logic [31:0] e2;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_flags", {busy, in_ready, out_valid}, 3'b010);
      check("rst_sel", sbox_sel, 3'd0);
      check("rst_sbox_in", sbox_in, 6'd0);
      check("rst_data", out_data, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_no_accept", {busy, in_ready}, 2'b01);

      run_word(48'h0, 32'hEFA72C4D, 14);
      run_word(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 13);

      // Stall in DONE for 20 cycles, with a stray in_valid that must be ignored.
      w = 48'h123456789ABC;
      e = model(w);
      exp_q.push_back(e);
      out_ready = 1'b0;
      in_data   = w;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      for (int j = 0; j < 20; j++) begin
         check("hold_flags", {busy, in_ready, out_valid}, 3'b101);
         check("hold_data", out_data, e);
         in_valid = (j == 5);
         in_data  = ~w;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("hold_last", out_valid, 1'b1);
      tick();
      check("release_flags", {busy, in_ready, out_valid}, 3'b010);
      check("release_data", out_data, e);

      // Reset in the fourth RUN cycle aborts with no output.
      in_data  = 48'hA5A5A5A5A5A5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("abort_k", sbox_sel, 3'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_flags", {busy, in_ready, out_valid}, 3'b010);
      check("abort_data", out_data, 32'd0);
      for (int j = 0; j < 10; j++) begin
         check("abort_quiet", out_valid, 1'b0);
         tick();
      end
      run_word(48'h3C3C3C3C3C3C, model(48'h3C3C3C3C3C3C), -1);

      // Back-to-back words with in_valid held; data changes mid-RUN are ignored.
      w  = 48'hFEDCBA987654;
      e  = model(w);
      e2 = model(48'h0F1E2D3C4B5A);
      exp_q.push_back(e);
      exp_q.push_back(e2);
      in_data  = w;
      in_valid = 1'b1;
      tick();
      in_data = 48'h0F1E2D3C4B5A;
      repeat (8) tick();
      check("b2b_c9_valid", {in_ready, out_valid}, 2'b01);
      check("b2b_c9_data", out_data, e);
      tick();
      check("b2b_c10_accept", {in_ready, out_valid}, 2'b10);
      tick();
      check("b2b_c11_run", {busy, sbox_sel}, {1'b1, 3'd0});
      in_valid = 1'b0;
      in_data  = 48'h555555555555;
      repeat (7) tick();
      check("b2b_c18_run", {sbox_sel, out_valid}, {3'd7, 1'b0});
      tick();
      check("b2b_c19_valid", out_valid, 1'b1);
      check("b2b_c19_data", out_data, e2);
      tick();
      check("b2b_c20_idle", {busy, in_ready, out_valid}, 3'b010);

      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
